// File: rtl/flex_counter_pkg.sv
// -----------------------------------------------------------------------------
// flex_counter_pkg
// Shared definitions for the flexible down-counter family.
//   state_t : counter state (IDLE = no valid load, RUN = counting,
//             EXPIRED = count reached zero after a load or countdown)
// -----------------------------------------------------------------------------
package flex_counter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

endpackage : flex_counter_pkg

// File: rtl/flex_down_counter.sv
// -----------------------------------------------------------------------------
// flex_down_counter
// Loadable down-counter with IDLE / RUN / EXPIRED tracking and registered
// status outputs.
//
// Parameters
//   SIZE          counter and load-value width in bits (default 4)
//
// Ports
//   clk           single clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   clear         force count to zero and state to IDLE
//   load          capture load_val into the counter (and reload register)
//   count_enable  request one decrement (or reload) this cycle
//   load_val      start value sampled when load=1
//   count_out     registered current count
//   zero_flag     registered level, high while EXPIRED
//   expire_pulse  registered one-cycle pulse on every entry into EXPIRED
//   busy          registered level, high while RUN
//
// Priority: rst > clear > load > count_enable; only the highest acts.
//
// Build option
//   FLEX_DOWN_COUNTER_RELOAD_EN  when defined, count_enable in EXPIRED
//                                restarts the countdown from the value of the
//                                last load (if non-zero). When undefined,
//                                EXPIRED holds until load, clear or rst and
//                                no reload register exists.
// -----------------------------------------------------------------------------
module flex_down_counter
    import flex_counter_pkg::*;
#(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            load,
    input  logic            count_enable,
    input  logic [SIZE-1:0] load_val,
    output logic [SIZE-1:0] count_out,
    output logic            zero_flag,
    output logic            expire_pulse,
    output logic            busy
);

    localparam logic [SIZE-1:0] ZERO = '0;
    localparam logic [SIZE-1:0] ONE  = {{(SIZE-1){1'b0}}, 1'b1};

    state_t          r_state;
    logic [SIZE-1:0] r_count;
    logic            r_zero_flag;
    logic            r_expire_pulse;
    logic            r_busy;

    state_t          w_state_nxt;
    logic [SIZE-1:0] w_count_nxt;
    logic            w_pulse_nxt;

`ifdef FLEX_DOWN_COUNTER_RELOAD_EN
    logic [SIZE-1:0] r_reload;
    logic [SIZE-1:0] w_reload_nxt;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so that no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_pulse_nxt = 1'b0;
`ifdef FLEX_DOWN_COUNTER_RELOAD_EN
        w_reload_nxt = r_reload;
`endif

        if (clear) begin
            // Reload register is deliberately left untouched.
            w_state_nxt = IDLE;
            w_count_nxt = ZERO;
        end else if (load) begin
            w_count_nxt = load_val;
`ifdef FLEX_DOWN_COUNTER_RELOAD_EN
            w_reload_nxt = load_val;
`endif
            if (load_val != ZERO) begin
                w_state_nxt = RUN;
            end else begin
                // A load of zero enters EXPIRED directly, re-pulsing even if
                // already there.
                w_state_nxt = EXPIRED;
                w_pulse_nxt = 1'b1;
            end
        end else if (count_enable) begin
            unique case (r_state)
                RUN: begin
                    // Count is non-zero in RUN; the guard keeps the decrement
                    // from ever wrapping should that invariant be broken.
                    if (r_count != ZERO) begin
                        w_count_nxt = r_count - ONE;
                    end
                    if (r_count <= ONE) begin
                        w_state_nxt = EXPIRED;
                        w_pulse_nxt = 1'b1;
                    end
                end
                EXPIRED: begin
`ifdef FLEX_DOWN_COUNTER_RELOAD_EN
                    if (r_reload != ZERO) begin
                        w_count_nxt = r_reload;
                        w_state_nxt = RUN;
                    end
`endif
                end
                default: ;  // IDLE ignores count_enable
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_count        <= ZERO;
            r_zero_flag    <= 1'b0;
            r_expire_pulse <= 1'b0;
            r_busy         <= 1'b0;
`ifdef FLEX_DOWN_COUNTER_RELOAD_EN
            r_reload       <= ZERO;
`endif
        end else begin
            r_state        <= w_state_nxt;
            r_count        <= w_count_nxt;
            r_zero_flag    <= (w_state_nxt == EXPIRED);
            r_expire_pulse <= w_pulse_nxt;
            r_busy         <= (w_state_nxt == RUN);
`ifdef FLEX_DOWN_COUNTER_RELOAD_EN
            r_reload       <= w_reload_nxt;
`endif
        end
    end

    assign count_out    = r_count;
    assign zero_flag    = r_zero_flag;
    assign expire_pulse = r_expire_pulse;
    assign busy         = r_busy;

endmodule : flex_down_counter

// File: tb/tb_flex_down_counter.sv
// -----------------------------------------------------------------------------
// tb_flex_down_counter
// Self-checking bench for flex_down_counter (SIZE=4). Directed scenarios check
// against fixed expectations; a randomized phase checks against a reference
// model that tracks only "has a valid load" plus the count value.
// Observed vector layout: {count_out, zero_flag, busy, expire_pulse}.
// Honors FLEX_DOWN_COUNTER_RELOAD_EN for reload-dependent expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_flex_down_counter;

    localparam int SIZE = 4;

`ifdef FLEX_DOWN_COUNTER_RELOAD_EN
    localparam bit RELOAD_EN = 1'b1;
`else
    localparam bit RELOAD_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            clear = 1'b0;
    logic            load = 1'b0;
    logic            count_enable = 1'b0;
    logic [SIZE-1:0] load_val = '0;
    logic [SIZE-1:0] count_out;
    logic            zero_flag;
    logic            expire_pulse;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_count  = 0;
    int m_reload = 0;
    bit m_valid  = 1'b0;   // a load happened since the last rst/clear
    bit m_pulse  = 1'b0;

    flex_down_counter #(.SIZE(SIZE)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .load         (load),
        .count_enable (count_enable),
        .load_val     (load_val),
        .count_out    (count_out),
        .zero_flag    (zero_flag),
        .expire_pulse (expire_pulse),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    logic [SIZE+2:0] w_obs;
    assign w_obs = {count_out, zero_flag, busy, expire_pulse};

    function automatic logic [SIZE+2:0] pack(input int cnt, input bit z,
                                             input bit b, input bit p);
        logic [SIZE-1:0] c;
        c = cnt[SIZE-1:0];
        return {c, z, b, p};
    endfunction

    // Expected outputs from the model: busy when loaded with a non-zero count,
    // zero_flag when loaded and the count is zero.
    function automatic logic [SIZE+2:0] model_vec();
        return pack(m_count, m_valid && (m_count == 0),
                    m_valid && (m_count > 0), m_pulse);
    endfunction

    task automatic model_step(input bit r, input bit c, input bit l,
                              input bit e, input int v);
        m_pulse = 1'b0;
        if (r) begin
            m_count = 0; m_reload = 0; m_valid = 1'b0;
        end else if (c) begin
            m_count = 0; m_valid = 1'b0;
        end else if (l) begin
            m_count = v; m_reload = v; m_valid = 1'b1;
            m_pulse = (v == 0);
        end else if (e && m_valid) begin
            if (m_count > 0) begin
                m_count = m_count - 1;
                m_pulse = (m_count == 0);
            end else if (RELOAD_EN && m_reload != 0) begin
                m_count = m_reload;
            end
        end
    endtask

    // Apply one cycle of inputs, then sample 1 ns after the edge.
    task automatic drive(input bit r, input bit c, input bit l,
                         input bit e, input int v);
        rst = r; clear = c; load = l; count_enable = e;
        load_val = v[SIZE-1:0];
        @(posedge clk);
        #1;
        model_step(r, c, l, e, v);
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0);
        n_checks++;
        if (w_obs !== pack(0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", w_obs, pack(0, 0, 0, 0));
        end
        drive(0, 0, 0, 1, 0);   // count_enable in IDLE is ignored
        n_checks++;
        if (w_obs !== pack(0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL idle_enable: got %h expected %h", w_obs, pack(0, 0, 0, 0));
        end
    endtask

    task automatic test_countdown();
        logic [SIZE+2:0] exp_seq [4];
        logic [SIZE+2:0] exp_after;
        exp_seq[0] = pack(3, 0, 1, 0);
        exp_seq[1] = pack(2, 0, 1, 0);
        exp_seq[2] = pack(1, 0, 1, 0);
        exp_seq[3] = pack(0, 1, 0, 1);
        drive(0, 0, 1, 0, 3);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) drive(0, 0, 0, 1, 0);
            n_checks++;
            if (w_obs !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL countdown_step%0d: got %h expected %h", i, w_obs, exp_seq[i]);
            end
        end
        exp_after = RELOAD_EN ? pack(3, 0, 1, 0) : pack(0, 1, 0, 0);
        drive(0, 0, 0, 1, 0);
        n_checks++;
        if (w_obs !== exp_after) begin
            n_fail++;
            $display("FAIL countdown_after_expire: got %h expected %h", w_obs, exp_after);
        end
    endtask

    task automatic test_load_enable_clear();
        drive(0, 0, 1, 1, 5);   // load wins over count_enable
        n_checks++;
        if (w_obs !== pack(5, 0, 1, 0)) begin
            n_fail++;
            $display("FAIL load_with_enable: got %h expected %h", w_obs, pack(5, 0, 1, 0));
        end
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0);
        n_checks++;
        if (w_obs !== pack(2, 0, 1, 0)) begin
            n_fail++;
            $display("FAIL count_to_2: got %h expected %h", w_obs, pack(2, 0, 1, 0));
        end
        drive(0, 0, 0, 0, 0);   // hold without enable
        n_checks++;
        if (w_obs !== pack(2, 0, 1, 0)) begin
            n_fail++;
            $display("FAIL hold: got %h expected %h", w_obs, pack(2, 0, 1, 0));
        end
        drive(0, 1, 0, 1, 0);   // clear wins over count_enable
        n_checks++;
        if (w_obs !== pack(0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL clear_in_run: got %h expected %h", w_obs, pack(0, 0, 0, 0));
        end
        drive(0, 0, 0, 1, 0);
        n_checks++;
        if (w_obs !== pack(0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL enable_after_clear: got %h expected %h", w_obs, pack(0, 0, 0, 0));
        end
    endtask

    task automatic test_load_zero();
        drive(0, 0, 1, 0, 0);
        n_checks++;
        if (w_obs !== pack(0, 1, 0, 1)) begin
            n_fail++;
            $display("FAIL load_zero: got %h expected %h", w_obs, pack(0, 1, 0, 1));
        end
        drive(0, 0, 0, 0, 0);
        n_checks++;
        if (w_obs !== pack(0, 1, 0, 0)) begin
            n_fail++;
            $display("FAIL pulse_drop: got %h expected %h", w_obs, pack(0, 1, 0, 0));
        end
        drive(0, 0, 1, 0, 0);   // re-entry via load 0 pulses again
        n_checks++;
        if (w_obs !== pack(0, 1, 0, 1)) begin
            n_fail++;
            $display("FAIL load_zero_again: got %h expected %h", w_obs, pack(0, 1, 0, 1));
        end
        drive(0, 0, 0, 1, 0);   // reload value is 0: hold, no pulse
        n_checks++;
        if (w_obs !== pack(0, 1, 0, 0)) begin
            n_fail++;
            $display("FAIL enable_zero_reload: got %h expected %h", w_obs, pack(0, 1, 0, 0));
        end
    endtask

    task automatic test_reload();
        logic [SIZE+2:0] exp_after;
        drive(0, 0, 1, 0, 2);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        n_checks++;
        if (w_obs !== pack(0, 1, 0, 1)) begin
            n_fail++;
            $display("FAIL reload_expire: got %h expected %h", w_obs, pack(0, 1, 0, 1));
        end
        exp_after = RELOAD_EN ? pack(2, 0, 1, 0) : pack(0, 1, 0, 0);
        drive(0, 0, 0, 1, 0);
        n_checks++;
        if (w_obs !== exp_after) begin
            n_fail++;
            $display("FAIL reload_enable: got %h expected %h", w_obs, exp_after);
        end
    endtask

    task automatic test_reset_mid_count();
        drive(0, 0, 1, 0, 15);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0);
        n_checks++;
        if (w_obs !== pack(11, 0, 1, 0)) begin
            n_fail++;
            $display("FAIL count_15_to_11: got %h expected %h", w_obs, pack(11, 0, 1, 0));
        end
        drive(1, 1, 1, 1, 7);   // rst outranks everything
        n_checks++;
        if (w_obs !== pack(0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL rst_mid_count: got %h expected %h", w_obs, pack(0, 0, 0, 0));
        end
        drive(0, 0, 0, 1, 0);
        n_checks++;
        if (w_obs !== pack(0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL after_rst_idle: got %h expected %h", w_obs, pack(0, 0, 0, 0));
        end
    endtask

    task automatic test_priority();
        drive(0, 0, 1, 0, 7);
        drive(0, 1, 1, 0, 9);   // clear outranks load
        n_checks++;
        if (w_obs !== pack(0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL clear_over_load: got %h expected %h", w_obs, pack(0, 0, 0, 0));
        end
    endtask

    task automatic test_random();
        bit r, c, l, e;
        int v;
        logic [SIZE+2:0] exp_v;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 39) == 0);
            c = ($urandom_range(0, 19) == 0);
            l = ($urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 3) != 0);
            v = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 15));
            drive(r, c, l, e, v);
            exp_v = model_vec();
            n_checks++;
            if (w_obs !== exp_v) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h expected %h", i, w_obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_load_enable_clear();
        test_load_zero();
        test_reload();
        test_reset_mid_count();
        test_priority();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_flex_down_counter

// File: doc/flex_down_counter.md
FLEX_DOWN_COUNTER -- requirements
Module: flex_down_counter

Interface
REQ-001 Parameter SIZE, default 4, SHALL set the counter and load-value width in bits.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 clear  input  1  SHALL force counter to zero and state to IDLE.
REQ-005 load  input  1  SHALL capture load_val into counter and reload register.
REQ-006 count_enable  input  1  SHALL request one decrement (or reload) per asserted cycle.
REQ-007 load_val  input  SIZE  SHALL be the start value sampled when load=1.
REQ-008 count_out  output  SIZE  SHALL be the registered current count.
REQ-009 zero_flag  output  1  SHALL be a registered level, high while state is EXPIRED.
REQ-010 expire_pulse  output  1  SHALL be a registered one-cycle pulse on every entry into EXPIRED.
REQ-011 busy  output  1  SHALL be a registered level, high while state is RUN.

Function
REQ-012 States SHALL be IDLE (no valid load), RUN (count_out>0), EXPIRED (count_out=0 after load or countdown).
REQ-013 Input priority SHALL be rst > clear > load > count_enable; only the highest active input acts in a cycle.
REQ-014 clear SHALL set count_out=0, state=IDLE, expire_pulse=0 next cycle; reload register unchanged.
REQ-015 load with load_val!=0 SHALL set count_out=load_val, state=RUN next cycle, from any state.
REQ-016 load with load_val=0 SHALL set count_out=0, state=EXPIRED, expire_pulse=1 next cycle.
REQ-017 load and count_enable in the same cycle SHALL load without decrementing.
REQ-018 In RUN, count_enable SHALL decrement count_out by 1 per cycle, latency one cycle.
REQ-019 In RUN with count_out=1 and count_enable=1, next cycle SHALL show count_out=0, state EXPIRED, zero_flag=1, expire_pulse=1.
REQ-020 count_enable SHALL be ignored in IDLE; count_out stays 0, no flag.
REQ-021 Without count_enable, count_out and state SHALL hold.
REQ-022 Decrement SHALL never wrap below zero; arithmetic is unsigned SIZE-bit.
REQ-023 expire_pulse SHALL deassert the cycle after it asserts unless EXPIRED is re-entered via another load of 0.

Reset
REQ-024 rst=1 at a clock edge SHALL set count_out=0, reload register=0, state=IDLE, zero_flag=0, expire_pulse=0, busy=0.
REQ-025 rst mid-count SHALL abort the countdown with no expire_pulse.

Configuration
REQ-026 Macro FLEX_DOWN_COUNTER_RELOAD_EN defined: in EXPIRED, count_enable with reload register!=0 SHALL set count_out=reload value, state RUN, zero_flag=0 next cycle; with reload register=0 SHALL hold EXPIRED without a new pulse.
REQ-027 Macro undefined: EXPIRED SHALL ignore count_enable and hold count_out=0 until load, clear or rst; reload register SHALL be omitted.

Structure
REQ-028 State enum typedef (IDLE, RUN, EXPIRED) SHALL live in shared package flex_counter_pkg.
REQ-029 Block SHALL be a single module with separate state register and next-state logic; no sub-module.

Verification (SIZE=4)
REQ-030 rst=1 one cycle -> count_out=0, zero_flag=0, busy=0, expire_pulse=0.
REQ-031 load_val=3 load, then count_enable held -> count_out 3,2,1,0; expire_pulse one cycle with count_out=0; zero_flag stays 1.
REQ-032 load_val=5 with load and count_enable same cycle -> count_out=5 (no decrement); clear during RUN at 2 -> count_out=0, IDLE, no pulse.
REQ-033 load_val=0 load -> count_out=0, zero_flag=1, expire_pulse=1 next cycle; count_enable in IDLE after rst -> count_out stays 0.
REQ-034 RELOAD_EN defined: load 2, count to 0, one more count_enable -> count_out=2, busy=1; undefined -> count_out stays 0.
REQ-035 load 15, count 4 cycles, rst asserted -> count_out=0, state IDLE, no expire_pulse.
